// File: rtl/rcvc_requester_pkg.sv
// Shared router definitions: output port codes, per-VC state encoding and
// the default mesh coordinate width.
package rcvc_requester_pkg;

  localparam int COORD_W   = 4;
  localparam int NUM_PORTS = 5;
  localparam int STATE_W   = 2;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_EAST  = 3'd1;
  localparam logic [2:0] PORT_WEST  = 3'd2;
  localparam logic [2:0] PORT_NORTH = 3'd3;
  localparam logic [2:0] PORT_SOUTH = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    VC_IDLE    = 2'd0,
    VC_RC_WAIT = 2'd1,
    VC_VA_WAIT = 2'd2,
    VC_ACTIVE  = 2'd3
  } vc_state_e;

  // Width of a downstream VC index; at least one bit even for a single VC.
  function automatic int ovc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rcvc_requester_vc.sv
// One input VC's request sequencer: head -> route computation -> downstream
// VC allocation -> active until the tail departs. All outputs are registered.
//
// Handshake semantics: grants (rc_en / vc_en) and pulses (head_valid /
// tail_done) are single-cycle strobes sampled on posedge clk; a strobe that
// arrives in a state that does not expect it is dropped, never remembered.
module rcvc_requester_vc
  import rcvc_requester_pkg::*;
#(
  parameter int no_ovc = 4,
  parameter int addr_w = COORD_W,
  parameter int cur_x  = 0,
  parameter int cur_y  = 0,
  parameter int ovc_w  = ovc_width(no_ovc)
) (
  input  logic                   clk,
  input  logic                   rs,
  input  logic                   head_valid,
  input  logic [2*addr_w-1:0]    dest,
  input  logic                   tail_done,
  input  logic                   rc_en,
  input  logic                   vc_en,
  input  logic [5*no_ovc-1:0]    out_vc_free,
  output logic                   handshake,
  output logic                   rc_done,
  output logic                   vc_done,
  output logic [2:0]             route,
  output logic [ovc_w-1:0]       ovc,
  output logic                   active,
  output logic                   claim_valid,
  output logic [2:0]             claim_port,
  output logic [ovc_w-1:0]       claim_ovc,
  output logic [STATE_W-1:0]     state
);

  localparam logic [addr_w-1:0] CUR_X_C = addr_w'(cur_x);
  localparam logic [addr_w-1:0] CUR_Y_C = addr_w'(cur_y);

  vc_state_e          r_state;
  logic               r_handshake;
  logic               r_rc_done;
  logic               r_vc_done;
  logic [2:0]         r_route;
  logic [ovc_w-1:0]   r_ovc;
  logic               r_active;
  logic               r_claim_valid;
  logic [2:0]         r_claim_port;
  logic [ovc_w-1:0]   r_claim_ovc;

  logic [no_ovc-1:0]  w_port_free;
  logic [ovc_w:0]     w_pick;

  // Dimension-ordered routing: resolve X first, then Y, unsigned compares.
  function automatic logic [2:0] xy_route(input logic [2*addr_w-1:0] d);
    logic [addr_w-1:0] dx;
    logic [addr_w-1:0] dy;
    dx = d[2*addr_w-1:addr_w];
    dy = d[addr_w-1:0];
    if (dx > CUR_X_C)      return PORT_EAST;
    else if (dx < CUR_X_C) return PORT_WEST;
    else if (dy > CUR_Y_C) return PORT_NORTH;
    else if (dy < CUR_Y_C) return PORT_SOUTH;
    else                   return PORT_LOCAL;
  endfunction

  // Lowest-index free VC; MSB of the result is the hit flag.
  function automatic logic [ovc_w:0] pick_free(input logic [no_ovc-1:0] v);
    logic [ovc_w:0] r;
    r = '0;
    for (int k = no_ovc - 1; k >= 0; k--) begin
      if (v[k]) r = {1'b1, ovc_w'(k)};
    end
    return r;
  endfunction

  // Select the free flags of the output port this VC was routed to.
  always_comb begin
    w_port_free = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_route == 3'(p)) w_port_free = out_vc_free[p*no_ovc +: no_ovc];
    end
  end

  assign w_pick = pick_free(w_port_free);

  // Per-VC state machine with registered pulse and hold outputs.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_state       <= VC_IDLE;
      r_handshake   <= 1'b0;
      r_rc_done     <= 1'b0;
      r_vc_done     <= 1'b0;
      r_route       <= '0;
      r_ovc         <= '0;
      r_active      <= 1'b0;
      r_claim_valid <= 1'b0;
      r_claim_port  <= '0;
      r_claim_ovc   <= '0;
    end else begin
      r_handshake   <= 1'b0;
      r_rc_done     <= 1'b0;
      r_vc_done     <= 1'b0;
      r_claim_valid <= 1'b0;
      r_claim_port  <= '0;
      r_claim_ovc   <= '0;
      case (r_state)
        VC_IDLE: begin
          if (head_valid) begin
            r_state     <= VC_RC_WAIT;
            r_handshake <= 1'b1;
          end
        end
        VC_RC_WAIT: begin
          if (rc_en) begin
            r_route   <= xy_route(dest);
            r_rc_done <= 1'b1;
            r_state   <= VC_VA_WAIT;
          end
        end
        VC_VA_WAIT: begin
          // No free downstream VC: stay put and wait for a later re-grant.
          if (vc_en && w_pick[ovc_w]) begin
            r_ovc         <= w_pick[ovc_w-1:0];
            r_vc_done     <= 1'b1;
            r_claim_valid <= 1'b1;
            r_claim_port  <= r_route;
            r_claim_ovc   <= w_pick[ovc_w-1:0];
            r_active      <= 1'b1;
            r_state       <= VC_ACTIVE;
          end
        end
        VC_ACTIVE: begin
          // A head arriving with the tail is dropped; the buffer re-presents it.
          if (tail_done) begin
            r_active <= 1'b0;
            r_state  <= VC_IDLE;
          end
        end
        default: r_state <= VC_IDLE;
      endcase
    end
  end

  assign handshake   = r_handshake;
  assign rc_done     = r_rc_done;
  assign vc_done     = r_vc_done;
  assign route       = r_route;
  assign ovc         = r_ovc;
  assign active      = r_active;
  assign claim_valid = r_claim_valid;
  assign claim_port  = r_claim_port;
  assign claim_ovc   = r_claim_ovc;
  assign state       = r_state;

endmodule

// File: rtl/rcvc_requester.sv
// Route-compute / VC-allocation requester: one independent sequencer per
// input VC. The arbiter grants one VC at a time, so at most one claim is
// live per cycle and the per-VC claims are merged by OR.
module rcvc_requester
  import rcvc_requester_pkg::*;
#(
  parameter int no_vc  = 12,
  parameter int no_ovc = 4,
  parameter int addr_w = COORD_W,
  parameter int cur_x  = 0,
  parameter int cur_y  = 0,
  parameter int ovc_w  = ovc_width(no_ovc)
) (
  input  logic                      clk,
  input  logic                      rs,
  input  logic [no_vc-1:0]          head_valids,
  input  logic [no_vc*2*addr_w-1:0] dests,
  input  logic [no_vc-1:0]          tail_dones,
  input  logic [no_vc-1:0]          rc_ens,
  input  logic [no_vc-1:0]          vc_ens,
  input  logic [5*no_ovc-1:0]       out_vc_free,
  output logic [no_vc-1:0]          handshakes,
  output logic [no_vc-1:0]          rc_dones,
  output logic [no_vc-1:0]          vc_dones,
  output logic [3*no_vc-1:0]        routes,
  output logic [no_vc*ovc_w-1:0]    ovcs,
  output logic [no_vc-1:0]          actives,
  output logic                      claim_valid,
  output logic [2:0]                claim_port,
  output logic [ovc_w-1:0]          claim_ovc,
  output logic [no_vc*STATE_W-1:0]  dbg_states
);

  logic [no_vc-1:0] w_cv;
  logic [2:0]       w_cp [no_vc];
  logic [ovc_w-1:0] w_co [no_vc];

  for (genvar g = 0; g < no_vc; g++) begin : g_vc
    rcvc_requester_vc #(
      .no_ovc (no_ovc),
      .addr_w (addr_w),
      .cur_x  (cur_x),
      .cur_y  (cur_y),
      .ovc_w  (ovc_w)
    ) u_vc (
      .clk         (clk),
      .rs          (rs),
      .head_valid  (head_valids[g]),
      .dest        (dests[g*2*addr_w +: 2*addr_w]),
      .tail_done   (tail_dones[g]),
      .rc_en       (rc_ens[g]),
      .vc_en       (vc_ens[g]),
      .out_vc_free (out_vc_free),
      .handshake   (handshakes[g]),
      .rc_done     (rc_dones[g]),
      .vc_done     (vc_dones[g]),
      .route       (routes[g*3 +: 3]),
      .ovc         (ovcs[g*ovc_w +: ovc_w]),
      .active      (actives[g]),
      .claim_valid (w_cv[g]),
      .claim_port  (w_cp[g]),
      .claim_ovc   (w_co[g]),
      .state       (dbg_states[g*STATE_W +: STATE_W])
    );
  end

  // Merge the (at most one) per-VC claim onto the shared claim bus.
  always_comb begin
    claim_valid = 1'b0;
    claim_port  = '0;
    claim_ovc   = '0;
    for (int i = 0; i < no_vc; i++) begin
      claim_valid = claim_valid | w_cv[i];
      claim_port  = claim_port  | w_cp[i];
      claim_ovc   = claim_ovc   | w_co[i];
    end
  end

endmodule

// File: tb/tb_rcvc_requester.sv
// Bench for rcvc_requester at router (1,1): directed scenarios followed by
// randomized traffic, every cycle compared against a phase-level model.
module tb_rcvc_requester;
  import rcvc_requester_pkg::*;

  localparam int NV = 12;
  localparam int NO = 4;
  localparam int AW = 4;
  localparam int CX = 1;
  localparam int CY = 1;
  localparam int OW = 2;

  logic               clk = 1'b0;
  logic               rs  = 1'b1;
  logic [NV-1:0]      head_valids = '0;
  logic [NV*2*AW-1:0] dests = '0;
  logic [NV-1:0]      tail_dones = '0;
  logic [NV-1:0]      rc_ens = '0;
  logic [NV-1:0]      vc_ens = '0;
  logic [5*NO-1:0]    out_vc_free = '0;
  logic [NV-1:0]      handshakes;
  logic [NV-1:0]      rc_dones;
  logic [NV-1:0]      vc_dones;
  logic [3*NV-1:0]    routes;
  logic [NV*OW-1:0]   ovcs;
  logic [NV-1:0]      actives;
  logic               claim_valid;
  logic [2:0]         claim_port;
  logic [OW-1:0]      claim_ovc;
  logic [NV*2-1:0]    dbg_states;

  rcvc_requester #(
    .no_vc(NV), .no_ovc(NO), .addr_w(AW), .cur_x(CX), .cur_y(CY)
  ) dut (
    .clk(clk), .rs(rs), .head_valids(head_valids), .dests(dests),
    .tail_dones(tail_dones), .rc_ens(rc_ens), .vc_ens(vc_ens),
    .out_vc_free(out_vc_free), .handshakes(handshakes), .rc_dones(rc_dones),
    .vc_dones(vc_dones), .routes(routes), .ovcs(ovcs), .actives(actives),
    .claim_valid(claim_valid), .claim_port(claim_port), .claim_ovc(claim_ovc),
    .dbg_states(dbg_states)
  );

  // Clock and reset timing: 10 ns period; inputs change 1 ns after posedge.
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: phase per VC (0 idle, 1 waiting route, 2 waiting VC,
  // 3 active), the route/ovc it last obtained, and the pulses due next.
  int            m_ph [NV];
  int            m_rt [NV];
  int            m_ov [NV];
  logic [NV-1:0] e_hs, e_rcd, e_vcd;
  logic          e_cv;
  logic [2:0]    e_cp;
  logic [OW-1:0] e_co;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
  endtask

  function automatic int ref_route(input int dx, input int dy);
    if (dx > CX) return 1;
    if (dx < CX) return 2;
    if (dy > CY) return 3;
    if (dy < CY) return 4;
    return 0;
  endfunction

  function automatic logic [1:0] ph_code(input int ph);
    case (ph)
      1:       return VC_RC_WAIT;
      2:       return VC_VA_WAIT;
      3:       return VC_ACTIVE;
      default: return VC_IDLE;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_ph[i] = 0; m_rt[i] = 0; m_ov[i] = 0;
    end
    e_hs = '0; e_rcd = '0; e_vcd = '0; e_cv = 1'b0; e_cp = '0; e_co = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    e_hs = '0; e_rcd = '0; e_vcd = '0; e_cv = 1'b0; e_cp = '0; e_co = '0;
    for (int i = 0; i < NV; i++) begin
      case (m_ph[i])
        0: if (head_valids[i]) begin m_ph[i] = 1; e_hs[i] = 1'b1; end
        1: if (rc_ens[i]) begin
             m_rt[i] = ref_route(int'(dests[i*2*AW+AW +: AW]), int'(dests[i*2*AW +: AW]));
             e_rcd[i] = 1'b1;
             m_ph[i] = 2;
           end
        2: if (vc_ens[i]) begin
             int first;
             first = -1;
             for (int k = NO - 1; k >= 0; k--)
               if (out_vc_free[m_rt[i]*NO + k]) first = k;
             if (first >= 0) begin
               m_ov[i] = first; e_vcd[i] = 1'b1;
               e_cv = 1'b1; e_cp = 3'(m_rt[i]); e_co = OW'(first);
               m_ph[i] = 3;
             end
           end
        3: if (tail_dones[i]) m_ph[i] = 0;
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    logic [3*NV-1:0]  er;
    logic [NV*OW-1:0] eo;
    logic [NV-1:0]    ea;
    logic [NV*2-1:0]  es;
    for (int i = 0; i < NV; i++) begin
      er[i*3 +: 3]   = 3'(m_rt[i]);
      eo[i*OW +: OW] = OW'(m_ov[i]);
      ea[i]          = (m_ph[i] == 3);
      es[i*2 +: 2]   = ph_code(m_ph[i]);
    end
    chk("handshakes",  64'(handshakes),  64'(e_hs));
    chk("rc_dones",    64'(rc_dones),    64'(e_rcd));
    chk("vc_dones",    64'(vc_dones),    64'(e_vcd));
    chk("routes",      64'(routes),      64'(er));
    chk("ovcs",        64'(ovcs),        64'(eo));
    chk("actives",     64'(actives),     64'(ea));
    chk("claim_valid", 64'(claim_valid), 64'(e_cv));
    chk("claim_port",  64'(claim_port),  64'(e_cp));
    chk("claim_ovc",   64'(claim_ovc),   64'(e_co));
    chk("states",      64'(dbg_states),  64'(es));
  endtask

  // Driver: one clock with the staged inputs, then compare and clear strobes.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    head_valids = '0; tail_dones = '0; rc_ens = '0; vc_ens = '0;
  endtask

  task automatic set_dest(input int vc, input int x, input int y);
    dests[vc*2*AW+AW +: AW] = AW'(x);
    dests[vc*2*AW +: AW]    = AW'(y);
  endtask

  // Random grant target: usually a VC in the wanted phase, sometimes any VC.
  function automatic int pick_vc(input int ph);
    int s;
    s = $urandom_range(0, NV - 1);
    if ($urandom_range(0, 3) == 0) return s;
    for (int j = 0; j < NV; j++)
      if (m_ph[(s + j) % NV] == ph) return (s + j) % NV;
    return s;
  endfunction

  initial begin
    model_reset();
    // Asynchronous reset asserted between edges: outputs clear at once.
    #2 rs = 1'b0;
    #1 check_all();
    repeat (2) @(posedge clk);
    #1 rs = 1'b1;

    // Head to VC0 towards (3,1); route grant in cycle 3 -> EAST.
    set_dest(0, 3, 1);
    head_valids[0] = 1'b1; cycle();
    chk("hs0_pulse", 64'(handshakes[0]), 64'd1);
    cycle();
    chk("hs0_single", 64'(handshakes[0]), 64'd0);
    rc_ens[0] = 1'b1; cycle();
    chk("rc_done0", 64'(rc_dones[0]), 64'd1);
    chk("route0_east", 64'(routes[2:0]), 64'd1);
    cycle();
    chk("rc_done0_clr", 64'(rc_dones[0]), 64'd0);

    // Allocation on EAST with only VC2 free there.
    out_vc_free = '0;
    out_vc_free[1*NO +: NO] = 4'b0100;
    vc_ens[0] = 1'b1; cycle();
    chk("ovc0", 64'(ovcs[1:0]), 64'd2);
    chk("claim_port_e", 64'(claim_port), 64'd1);
    chk("claim_ovc_e", 64'(claim_ovc), 64'd2);
    chk("vc_done0", 64'(vc_dones[0]), 64'd1);
    cycle();
    chk("claim_single", 64'(claim_valid), 64'd0);

    // Routes for LOCAL, SOUTH and WEST destinations.
    set_dest(1, 1, 1); set_dest(2, 1, 0); set_dest(3, 0, 2);
    head_valids[3:1] = 3'b111; cycle();
    rc_ens[1] = 1'b1; cycle();
    rc_ens[2] = 1'b1; cycle();
    rc_ens[3] = 1'b1; cycle();
    chk("route1_local", 64'(routes[5:3]), 64'd0);
    chk("route2_south", 64'(routes[8:6]), 64'd4);
    chk("route3_west", 64'(routes[11:9]), 64'd2);

    // Nothing free: grant is absorbed, VC1 keeps waiting; then VC0 frees.
    out_vc_free = '0;
    vc_ens[1] = 1'b1; cycle();
    chk("no_vc_done1", 64'(vc_dones[1]), 64'd0);
    chk("vc1_va_wait", 64'(dbg_states[3:2]), 64'(VC_VA_WAIT));
    cycle();
    out_vc_free[0] = 1'b1;
    vc_ens[1] = 1'b1; cycle();
    chk("vc_done1", 64'(vc_dones[1]), 64'd1);
    chk("ovc1_zero", 64'(ovcs[3:2]), 64'd0);
    chk("claim1_valid", 64'(claim_valid), 64'd1);

    // Stray route grant to idle VC5 and stray head to active VC1.
    rc_ens[5] = 1'b1; cycle();
    chk("stray_rc", 64'(rc_dones), 64'd0);
    head_valids[1] = 1'b1; cycle();
    chk("stray_head", 64'(handshakes), 64'd0);
    chk("vc1_active", 64'(actives[1]), 64'd1);

    // Tail and head together on VC1: idle for one cycle, head dropped.
    tail_dones[1] = 1'b1; head_valids[1] = 1'b1; cycle();
    chk("vc1_idle", 64'(dbg_states[3:2]), 64'(VC_IDLE));
    chk("vc1_route_held", 64'(routes[5:3]), 64'd0);
    head_valids[1] = 1'b1; cycle();
    chk("vc1_rehead", 64'(handshakes[1]), 64'd1);

    // VC2 active on SOUTH, VC3 still waiting; then reset mid-operation.
    out_vc_free = '0;
    out_vc_free[4*NO +: NO] = 4'b1000;
    vc_ens[2] = 1'b1; cycle();
    chk("ovc2", 64'(ovcs[5:4]), 64'd3);
    out_vc_free = '1;
    vc_ens[3] = 1'b1;
    #2 rs = 1'b0;
    model_reset();
    #1 check_all();
    chk("rst_actives", 64'(actives), 64'd0);
    chk("rst_routes", 64'(routes), 64'd0);
    @(posedge clk);
    #1 check_all();
    chk("rst_no_claim", 64'(claim_valid), 64'd0);
    rs = 1'b1;
    vc_ens = '0;
    set_dest(3, 2, 1);
    head_valids[3] = 1'b1; cycle();
    chk("post_rst_hs3", 64'(handshakes[3]), 64'd1);
    rc_ens[3] = 1'b1; cycle();
    chk("post_rst_route3", 64'(routes[11:9]), 64'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NV; i++) begin
        if (m_ph[i] == 0) begin
          set_dest(i, $urandom_range(0, 3), $urandom_range(0, 3));
          if ($urandom_range(0, 3) == 0) head_valids[i] = 1'b1;
        end else if ($urandom_range(0, 15) == 0) begin
          head_valids[i] = 1'b1;
        end
        if ($urandom_range(0, 7) == 0) tail_dones[i] = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) rc_ens[pick_vc(1)] = 1'b1;
      if ($urandom_range(0, 1) == 1) vc_ens[pick_vc(2)] = 1'b1;
      out_vc_free = 20'($urandom) & 20'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
